// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer.
// Optional feature: define STORE_BUFFER_FORWARD_EN to enable load forwarding (see store_buffer.sv).
package sb_pkg;

    // Stores are tracked on a 17-bit byte address.
    localparam int ADDR_BITS = 17;

    // Access size encoding shared by stores, loads and the RAM port.
    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_WORD = 1'b1;

    // Per-entry tag. Store data is kept in a separate WIDTH-wide array in the top
    // so the data width can follow the WIDTH parameter.
    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic                 word;
    } sb_entry_t;

    // Last byte covered by an access, computed one bit wider so it never wraps.
    function automatic logic [ADDR_BITS:0] span_end(input logic [ADDR_BITS-1:0] addr,
                                                    input logic                 word);
        logic [ADDR_BITS:0] last;
        if (word == SZ_WORD) begin
            last = {1'b0, addr} + {{(ADDR_BITS-1){1'b0}}, 2'd3};
        end else begin
            last = {1'b0, addr};
        end
        return last;
    endfunction

endpackage

// File: rtl/sb_overlap.sv
// Combinational comparator between one store-buffer entry and the current load.
// overlap_o: the byte ranges intersect; exact_o: same address and same size.
module sb_overlap
    import sb_pkg::*;
(
    input  logic                 ent_valid_i,
    input  logic [ADDR_BITS-1:0] ent_addr_i,
    input  logic                 ent_word_i,
    input  logic [ADDR_BITS-1:0] ld_addr_i,
    input  logic                 ld_word_i,
    output logic                 overlap_o,
    output logic                 exact_o
);

    logic [ADDR_BITS:0] ent_lo_s;
    logic [ADDR_BITS:0] ent_hi_s;
    logic [ADDR_BITS:0] ld_lo_s;
    logic [ADDR_BITS:0] ld_hi_s;

    // Interval intersection test on non-wrapping 18-bit byte ranges.
    always_comb begin
        ent_lo_s  = {1'b0, ent_addr_i};
        ent_hi_s  = span_end(ent_addr_i, ent_word_i);
        ld_lo_s   = {1'b0, ld_addr_i};
        ld_hi_s   = span_end(ld_addr_i, ld_word_i);
        overlap_o = ent_valid_i && (ent_lo_s <= ld_hi_s) && (ld_lo_s <= ent_hi_s);
        exact_o   = overlap_o && (ent_addr_i == ld_addr_i) && (ent_word_i == ld_word_i);
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the CPU and a single-port data RAM.
// Loads own the RAM port unless they hit a pending store; otherwise the oldest
// store drains one per cycle. Drained stores are addressed by addr[16:0].
// Optional feature macro: STORE_BUFFER_FORWARD_EN -- forward an exactly matching
// youngest pending store to the load instead of stalling.
module store_buffer
    import sb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             st_valid_i,
    output logic             st_ready_o,
    input  logic             st_word_i,
    input  logic [WIDTH-1:0] st_addr_i,
    input  logic [WIDTH-1:0] st_data_i,
    input  logic             ld_valid_i,
    input  logic             ld_word_i,
    input  logic [WIDTH-1:0] ld_addr_i,
    output logic             ld_stall_o,
    output logic [WIDTH-1:0] ld_data_o,
    output logic             mem_we_o,
    output logic             mem_word_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wd_o,
    input  logic [WIDTH-1:0] mem_rd_i,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    sb_entry_t        tag_q  [DEPTH];
    sb_entry_t        tag_d  [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    logic [DEPTH-1:0] ent_valid_s;
    logic [DEPTH-1:0] overlap_s;
    logic [DEPTH-1:0] exact_s;
    logic             any_overlap_s;
    logic             yng_exact_s;
    logic [PTR_W-1:0] yng_idx_s;
    logic             fwd_ok_s;
    logic [WIDTH-1:0] fwd_data_s;
    logic             load_port_s;
    logic             drain_s;
    logic             push_s;
    logic             unused_addr_s;

    // Upper store-address bits are not tracked by the buffer.
    assign unused_addr_s = ^st_addr_i[WIDTH-1:ADDR_BITS];

    // An entry is pending when its distance from head is below count.
    always_comb begin
        logic [PTR_W-1:0] off_v;
        ent_valid_s = '0;
        off_v       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off_v          = PTR_W'(i) - head_q;
            ent_valid_s[i] = ({1'b0, off_v} < count_q);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ovl
        sb_overlap u_ovl (
            .ent_valid_i (ent_valid_s[g]),
            .ent_addr_i  (tag_q[g].addr),
            .ent_word_i  (tag_q[g].word),
            .ld_addr_i   (ld_addr_i[ADDR_BITS-1:0]),
            .ld_word_i   (ld_word_i),
            .overlap_o   (overlap_s[g]),
            .exact_o     (exact_s[g])
        );
    end

    // Walk entries oldest to youngest so the last hit is the youngest overlap.
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        any_overlap_s = 1'b0;
        yng_exact_s   = 1'b0;
        yng_idx_s     = '0;
        idx_v         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_v = head_q + PTR_W'(k);
            if (overlap_s[idx_v]) begin
                any_overlap_s = 1'b1;
                yng_exact_s   = exact_s[idx_v];
                yng_idx_s     = idx_v;
            end else begin
                any_overlap_s = any_overlap_s;
            end
        end
    end

`ifdef STORE_BUFFER_FORWARD_EN
    assign fwd_ok_s = ld_valid_i && any_overlap_s && yng_exact_s;
`else
    logic unused_fwd_s;
    assign unused_fwd_s = yng_exact_s;
    assign fwd_ok_s     = 1'b0;
`endif

    // Port arbitration, stall and load-data selection.
    always_comb begin
        st_ready_o  = (count_q != CNT_W'(DEPTH));
        empty_o     = (count_q == CNT_W'(0));
        push_s      = st_valid_i && st_ready_o;
        load_port_s = ld_valid_i && !any_overlap_s;
        drain_s     = !load_port_s && (count_q != CNT_W'(0));
        ld_stall_o  = ld_valid_i && any_overlap_s && !fwd_ok_s;
        mem_we_o    = 1'b0;
        mem_word_o  = ld_word_i;
        mem_addr_o  = ld_addr_i;
        mem_wd_o    = '0;
        if (drain_s) begin
            mem_we_o   = 1'b1;
            mem_word_o = tag_q[head_q].word;
            mem_addr_o = WIDTH'(tag_q[head_q].addr);
            mem_wd_o   = data_q[head_q];
        end else begin
            mem_we_o   = 1'b0;
        end
        if (tag_q[yng_idx_s].word == SZ_WORD) begin
            fwd_data_s = data_q[yng_idx_s];
        end else begin
            fwd_data_s = {{(WIDTH-8){data_q[yng_idx_s][7]}}, data_q[yng_idx_s][7:0]};
        end
        if (fwd_ok_s) begin
            ld_data_o = fwd_data_s;
        end else begin
            ld_data_o = mem_rd_i;
        end
    end

    // Next pointers, count and entry storage.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        tag_d  = tag_q;
        data_d = data_q;
        if (push_s) begin
            tag_d[tail_q].addr = st_addr_i[ADDR_BITS-1:0];
            tag_d[tail_q].word = st_word_i;
            data_d[tail_q]     = st_data_i;
            tail_d             = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        if (drain_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        case ({push_s, drain_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: cleared immediately by reset so pending stores are dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload: not reset, only meaningful while counted as pending.
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with a byte-addressed RAM model.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_ready, st_word;
    logic [31:0] st_addr, st_data;
    logic        ld_valid, ld_word, ld_stall;
    logic [31:0] ld_addr, ld_data;
    logic        mem_we, mem_word;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        empty;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ram [0:1023];
    logic [31:0] wa_q[$];
    logic [31:0] wdat_q[$];
    logic [9:0]  ra;

    store_buffer #(.WIDTH(32), .DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .st_valid_i(st_valid), .st_ready_o(st_ready), .st_word_i(st_word),
        .st_addr_i(st_addr), .st_data_i(st_data),
        .ld_valid_i(ld_valid), .ld_word_i(ld_word), .ld_addr_i(ld_addr),
        .ld_stall_o(ld_stall), .ld_data_o(ld_data),
        .mem_we_o(mem_we), .mem_word_o(mem_word), .mem_addr_o(mem_addr),
        .mem_wd_o(mem_wd), .mem_rd_i(mem_rd), .empty_o(empty)
    );

    always #5 clk = ~clk;

    // Little-endian RAM: combinational read, byte reads sign-extended.
    assign ra = mem_addr[9:0];
    always_comb begin
        if (mem_word) mem_rd = {ram[ra + 10'd3], ram[ra + 10'd2], ram[ra + 10'd1], ram[ra]};
        else          mem_rd = {{24{ram[ra][7]}}, ram[ra]};
    end

    // RAM write port and write log.
    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_word) begin
                ram[ra] = mem_wd[7:0];            ram[ra + 10'd1] = mem_wd[15:8];
                ram[ra + 10'd2] = mem_wd[23:16];  ram[ra + 10'd3] = mem_wd[31:24];
            end else begin
                ram[ra] = mem_wd[7:0];
            end
            wa_q.push_back(mem_addr);
            wdat_q.push_back(mem_wd);
        end
    end

    function automatic logic [31:0] ram_word(input logic [9:0] a);
        return {ram[a + 10'd3], ram[a + 10'd2], ram[a + 10'd1], ram[a]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic word, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1; st_word = word; st_addr = a; st_data = d;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; st_valid = 1'b0; st_word = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_word = 1'b0; ld_addr = '0;
        #1;
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", st_ready); end
        total++; if (empty !== 1'b1)    begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
        total++; if (mem_we !== 1'b0)   begin bad++; $display("FAIL rst_we got=%b exp=0", mem_we); end
        total++; if (ld_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", ld_stall); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_drain();
        int n0;
        n0 = wa_q.size();
        st_valid = 1'b1; st_word = 1'b1; st_addr = 32'h100; st_data = 32'hDEADBEEF;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL drain_same_cycle_we got=%b exp=0", mem_we); end
        tick();
        st_valid = 1'b0;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL drain_we got=%b exp=1", mem_we); end
        total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL drain_addr got=%h exp=100", mem_addr); end
        total++; if (mem_word !== 1'b1) begin bad++; $display("FAIL drain_word got=%b exp=1", mem_word); end
        total++; if (mem_wd !== 32'hDEADBEEF) begin bad++; $display("FAIL drain_wd got=%h exp=deadbeef", mem_wd); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL drain_busy got=%b exp=0", empty); end
        tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
        total++; if (ram_word(10'h100) !== 32'hDEADBEEF) begin bad++; $display("FAIL drain_ram got=%h exp=deadbeef", ram_word(10'h100)); end
        total++; if (wa_q.size() !== n0 + 1) begin bad++; $display("FAIL drain_nwrites got=%0d exp=%0d", wa_q.size(), n0 + 1); end
    endtask

    task automatic test_fill_with_load();
        int n0;
        n0 = wa_q.size();
        ram[10'h200] = 8'h78; ram[10'h201] = 8'h56; ram[10'h202] = 8'h34; ram[10'h203] = 8'h12;
        ld_valid = 1'b1; ld_word = 1'b1; ld_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_word = 1'b1; st_addr = 32'h300 + 32'(4 * i); st_data = 32'(i + 1);
            #1;
            total++; if (mem_we !== 1'b0 || ld_stall !== 1'b0 || ld_data !== 32'h12345678) begin
                bad++; $display("FAIL fill_load_%0d we=%b stall=%b data=%h exp we=0 stall=0 data=12345678", i, mem_we, ld_stall, ld_data);
            end
            tick();
        end
        st_valid = 1'b0;
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", st_ready); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL fill_no_drain got=%b exp=0", mem_we); end
        ram[10'h200] = 8'h99;
        #1;
        total++; if (ld_data !== 32'h12345699) begin bad++; $display("FAIL fill_track got=%h exp=12345699", ld_data); end
        total++; if (wa_q.size() !== n0) begin bad++; $display("FAIL fill_nwrites got=%0d exp=%0d", wa_q.size(), n0); end
    endtask

    task automatic test_full_push_drain();
        int n0;
        int cyc;
        n0 = wa_q.size();
        ld_valid = 1'b0;
        st_valid = 1'b1; st_word = 1'b1; st_addr = 32'h310; st_data = 32'd5;
        #1;
        total++; if (st_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h300) begin
            bad++; $display("FAIL full_first ready=%b we=%b addr=%h exp ready=0 we=1 addr=300", st_ready, mem_we, mem_addr);
        end
        tick();
        total++; if (st_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h304) begin
            bad++; $display("FAIL full_second ready=%b we=%b addr=%h exp ready=1 we=1 addr=304", st_ready, mem_we, mem_addr);
        end
        tick();
        st_valid = 1'b0;
        total++; if (st_ready !== 1'b1 || empty !== 1'b0 || mem_addr !== 32'h308) begin
            bad++; $display("FAIL full_third ready=%b empty=%b addr=%h exp ready=1 empty=0 addr=308", st_ready, empty, mem_addr);
        end
        cyc = 0;
        while (empty !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        total++; if (cyc !== 3) begin bad++; $display("FAIL full_drain_cycles got=%0d exp=3", cyc); end
        total++; if (wa_q.size() !== n0 + 5) begin
            bad++; $display("FAIL full_nwrites got=%0d exp=%0d", wa_q.size(), n0 + 5);
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++; if (wa_q[n0 + i] !== 32'h300 + 32'(4 * i) || wdat_q[n0 + i] !== 32'(i + 1)) begin
                    bad++; $display("FAIL full_order_%0d addr=%h data=%h exp addr=%h data=%h", i, wa_q[n0 + i], wdat_q[n0 + i], 32'h300 + 32'(4 * i), 32'(i + 1));
                end
            end
        end
    endtask

    task automatic test_stall();
        push_store(1'b0, 32'h103, 32'h00000080);
        ld_valid = 1'b1; ld_word = 1'b1; ld_addr = 32'h100;
        #1;
        total++; if (ld_stall !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h103 || mem_word !== 1'b0) begin
            bad++; $display("FAIL stall_hit stall=%b we=%b addr=%h word=%b exp 1 1 103 0", ld_stall, mem_we, mem_addr, mem_word);
        end
        tick();
        total++; if (ld_stall !== 1'b0 || ld_data !== 32'h80ADBEEF) begin
            bad++; $display("FAIL stall_release stall=%b data=%h exp stall=0 data=80adbeef", ld_stall, ld_data);
        end
        ld_valid = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        push_store(1'b0, 32'h10, 32'h000000F0);
        ld_valid = 1'b1; ld_word = 1'b0; ld_addr = 32'h10;
        #1;
`ifdef STORE_BUFFER_FORWARD_EN
        total++; if (ld_stall !== 1'b0 || ld_data !== 32'hFFFFFFF0 || mem_we !== 1'b1) begin
            bad++; $display("FAIL fwd_hit stall=%b data=%h we=%b exp 0 fffffff0 1", ld_stall, ld_data, mem_we);
        end
`else
        total++; if (ld_stall !== 1'b1 || mem_we !== 1'b1) begin
            bad++; $display("FAIL fwd_stall stall=%b we=%b exp 1 1", ld_stall, mem_we);
        end
`endif
        tick();
        total++; if (ld_stall !== 1'b0 || ld_data !== 32'hFFFFFFF0 || empty !== 1'b1) begin
            bad++; $display("FAIL fwd_after stall=%b data=%h empty=%b exp 0 fffffff0 1", ld_stall, ld_data, empty);
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_boundary();
        push_store(1'b1, 32'h20, 32'hAABBCCDD);
        ld_valid = 1'b1; ld_word = 1'b0; ld_addr = 32'h24;
        #1;
        total++; if (ld_stall !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL bnd_24 stall=%b we=%b exp 0 0", ld_stall, mem_we); end
        ld_addr = 32'h23;
        #1;
        total++; if (ld_stall !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL bnd_23 stall=%b we=%b exp 1 1", ld_stall, mem_we); end
        ld_word = 1'b1; ld_addr = 32'h1D;
        #1;
        total++; if (ld_stall !== 1'b1) begin bad++; $display("FAIL bnd_1d stall=%b exp 1", ld_stall); end
        ld_addr = 32'h1C;
        #1;
        total++; if (ld_stall !== 1'b0) begin bad++; $display("FAIL bnd_1c stall=%b exp 0", ld_stall); end
        ld_valid = 1'b0;
        tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL bnd_empty got=%b exp 1", empty); end
    endtask

    task automatic test_reset_mid_drain();
        int n0;
        ld_valid = 1'b1; ld_word = 1'b1; ld_addr = 32'h200;
        push_store(1'b1, 32'h400, 32'h11);
        push_store(1'b1, 32'h404, 32'h22);
        push_store(1'b1, 32'h408, 32'h33);
        ld_valid = 1'b0;
        #1;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rmd_draining got=%b exp 1", mem_we); end
        n0 = wa_q.size();
        rst = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1) begin
            bad++; $display("FAIL rmd_async we=%b empty=%b ready=%b exp 0 1 1", mem_we, empty, st_ready);
        end
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        total++; if (wa_q.size() !== n0 || mem_we !== 1'b0 || empty !== 1'b1) begin
            bad++; $display("FAIL rmd_after writes=%0d we=%b empty=%b exp writes=%0d we=0 empty=1", wa_q.size(), mem_we, empty, n0);
        end
        total++; if (ram_word(10'h400) !== 32'h0) begin bad++; $display("FAIL rmd_ram got=%h exp 0", ram_word(10'h400)); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        test_reset();
        test_drain();
        test_fill_with_load();
        test_full_push_drain();
        test_stall();
        test_forward();
        test_boundary();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
